// File: rtl/alu_pipe_pkg.sv
// Shared opcode map and flag bundle for the pipelined ALU.
// Imported by alu_core, alu_pipe and alu_pipe_if.
package alu_pipe_pkg;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD  = 3'd0;
  localparam logic [OPW-1:0] OP_SUB  = 3'd1;
  localparam logic [OPW-1:0] OP_ADDS = 3'd2;
  localparam logic [OPW-1:0] OP_SUBS = 3'd3;
  localparam logic [OPW-1:0] OP_AND  = 3'd4;
  localparam logic [OPW-1:0] OP_OR   = 3'd5;
  localparam logic [OPW-1:0] OP_XOR  = 3'd6;
  localparam logic [OPW-1:0] OP_CMP  = 3'd7;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;
endpackage

// File: rtl/alu_pipe_if.sv
// Beat-level handshake bundle around alu_pipe.
// master: beat producer / result consumer; slave: the ALU side.
interface alu_pipe_if
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output valid, opcode, a, b, out_ready,
    input  ready, out_valid, dout,
    input  carry, ovf, zero, neg
  );

  modport slave (
    input  valid, opcode, a, b, out_ready,
    output ready, out_valid, dout,
    output carry, ovf, zero, neg
  );
endinterface

// File: rtl/alu_pipe_core.sv
// alu_core: combinational result plus carry/ovf/zero/neg.
// Ports: op, a, b in; res, flg out.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output flags_t           flg
);
  localparam int M = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             add_v;
  logic             sub_v;
  logic             slt;
  logic [WIDTH-1:0] smax;
  logic [WIDTH-1:0] smin;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    add_v = (a[M] == b[M]) && (sum[M] != a[M]);
    sub_v = (a[M] != b[M]) && (dif[M] != a[M]);
    slt   = $signed(a) < $signed(b);
    smax  = {1'b0, {M{1'b1}}};
    smin  = {1'b1, {M{1'b0}}};
    res   = '0;
    flg   = '0;
    unique case (op)
      OP_ADD: begin
        res       = sum[M:0];
        flg.carry = sum[WIDTH];
        flg.ovf   = add_v;
      end
      OP_SUB: begin
        res       = dif[M:0];
        flg.carry = dif[WIDTH];
        flg.ovf   = sub_v;
      end
      // Overflow direction follows the sign of A.
      OP_ADDS: begin
        res       = add_v ? (a[M] ? smin : smax)
                          : sum[M:0];
        flg.carry = sum[WIDTH];
        flg.ovf   = add_v;
      end
      OP_SUBS: begin
        res       = sub_v ? (a[M] ? smin : smax)
                          : dif[M:0];
        flg.carry = dif[WIDTH];
        flg.ovf   = sub_v;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_CMP: begin
        res       = {{M{1'b0}}, slt};
        flg.carry = dif[WIDTH];
      end
      default: res = '0;
    endcase
    flg.zero = (res == '0);
    flg.neg  = res[M];
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: alu_core followed by STAGES elastic register stages.
// Ports: iCLK/iRST, input beat (iVALID/oREADY/op/A/B), result beat.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic [OPW-1:0]   iOPCODE,
  input  logic [WIDTH-1:0] iDATAIN1,
  input  logic [WIDTH-1:0] iDATAIN2,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [WIDTH-1:0] oDATAOUT,
  output logic             oCARRY,
  output logic             oOVF,
  output logic             oZERO,
  output logic             oNEG
);
  logic             adv;
  logic             last_v;
  logic [WIDTH-1:0] last_r;
  flags_t           last_f;
  logic [WIDTH-1:0] c_res;
  flags_t           c_flg;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op  (iOPCODE),
    .a   (iDATAIN1),
    .b   (iDATAIN2),
    .res (c_res),
    .flg (c_flg)
  );

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic             v_in;
    logic [WIDTH-1:0] r_in;
    flags_t           f_in;
    logic             v_d;
    logic             v_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    flags_t           f_d;
    flags_t           f_q;

    if (s == 0) begin : g_head
      assign v_in = iVALID;
      assign r_in = c_res;
      assign f_in = c_flg;
    end else begin : g_body
      assign v_in = g_st[s-1].v_q;
      assign r_in = g_st[s-1].r_q;
      assign f_in = g_st[s-1].f_q;
    end

    always_comb begin
      v_d = v_q;
      r_d = r_q;
      f_d = f_q;
      if (adv) begin
        v_d = v_in;
        r_d = r_in;
        f_d = f_in;
      end
    end

    always_ff @(posedge iCLK) begin
      if (iRST) begin
        v_q <= 1'b0;
        r_q <= '0;
        f_q <= '0;
      end else begin
        v_q <= v_d;
        r_q <= r_d;
        f_q <= f_d;
      end
    end
  end

  assign last_v = g_st[STAGES-1].v_q;
  assign last_r = g_st[STAGES-1].r_q;
  assign last_f = g_st[STAGES-1].f_q;

  // Whole pipe moves together; it only freezes
  // when the output stage holds an unaccepted beat.
  always_comb begin
    adv      = !last_v || iREADY;
    oREADY   = adv && !iRST;
    oVALID   = last_v && !iRST;
    oDATAOUT = iRST ? '0 : last_r;
    oCARRY   = !iRST && last_f.carry;
    oOVF     = !iRST && last_f.ovf;
    oZERO    = !iRST && last_f.zero;
    oNEG     = !iRST && last_f.neg;
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at STAGES = 1, 2 and 4.
// All three copies share stimulus; each keeps its own queue.
module tb_alu_pipe;
  typedef struct {
    logic [11:0] e;
    int          acyc;
    int          stl;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic        rdy = 1'b1;
  logic [2:0]  op = '0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        lit_on = 1'b0;
  logic [11:0] lit_exp = '0;
  logic        end_req = 1'b0;

  logic [2:0]  ov;
  logic [2:0]  rd;
  logic [11:0] got [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int stalls [3] = '{0, 0, 0};
  int pops [3] = '{0, 0, 0};
  logic pst [3] = '{1'b0, 1'b0, 1'b0};
  logic [11:0] pout [3];
  int seq_acc = 0;
  int seq_delta = 0;

  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int ST = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    alu_pipe_if #(.WIDTH(8)) bus ();
    assign bus.valid = vin;
    assign bus.opcode = op;
    assign bus.a = a;
    assign bus.b = b;
    assign bus.out_ready = rdy;
    assign ov[k] = bus.out_valid;
    assign rd[k] = bus.ready;
    assign got[k] = {bus.neg, bus.zero, bus.ovf,
                     bus.carry, bus.dout};
    alu_pipe #(.WIDTH(8), .STAGES(ST)) dut (
      .iCLK     (clk),
      .iRST     (rst),
      .iVALID   (bus.valid),
      .oREADY   (bus.ready),
      .iOPCODE  (bus.opcode),
      .iDATAIN1 (bus.a),
      .iDATAIN2 (bus.b),
      .oVALID   (bus.out_valid),
      .iREADY   (bus.out_ready),
      .oDATAOUT (bus.dout),
      .oCARRY   (bus.carry),
      .oOVF     (bus.ovf),
      .oZERO    (bus.zero),
      .oNEG     (bus.neg)
    );
  end

  // Packed as {neg, zero, ovf, carry, result[7:0]}.
  function automatic logic [11:0] model(
    input logic [2:0] o,
    input logic [7:0] x,
    input logic [7:0] y
  );
    int ux, uy, sx, sy, t, r;
    bit c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    r = 0;
    c = 0;
    v = 0;
    case (o)
      3'd0: begin
        t = ux + uy;
        r = t % 256;
        c = t > 255;
        v = (sx + sy > 127) || (sx + sy < -128);
      end
      3'd1: begin
        r = (ux - uy + 256) % 256;
        c = ux < uy;
        v = (sx - sy > 127) || (sx - sy < -128);
      end
      3'd2: begin
        t = sx + sy;
        c = (ux + uy) > 255;
        v = (t > 127) || (t < -128);
        r = (t > 127) ? 127 : (t < -128) ? 128 : (t + 256) % 256;
      end
      3'd3: begin
        t = sx - sy;
        c = ux < uy;
        v = (t > 127) || (t < -128);
        r = (t > 127) ? 127 : (t < -128) ? 128 : (t + 256) % 256;
      end
      3'd4: r = ux & uy;
      3'd5: r = ux | uy;
      3'd6: r = ux ^ uy;
      default: begin
        r = (sx < sy) ? 1 : 0;
        c = ux < uy;
      end
    endcase
    return {r >= 128, r == 0, v, c, 8'(r)};
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got %h required %h",
               nm, k, cyc, act, exp);
    end
  endtask

  task automatic mon(input int k, input int st, ref ent_t q[$]);
    ent_t h;
    if (rst) begin
      chk("reset_out", k, 32'({ov[k], rd[k], got[k]}), 32'd0);
      q.delete();
      pst[k] = 1'b0;
      return;
    end
    if (ov[k]) begin
      if (pst[k]) chk("hold", k, 32'(got[k]), 32'(pout[k]));
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected inst=%0d cyc=%0d got %h required none",
                 k, cyc, got[k]);
      end else begin
        h = q[0];
        chk("result", k, 32'(got[k]), 32'(h.e));
        if (h.stl == stalls[k])
          chk("latency", k, cyc - h.acyc, st);
        if (rdy) begin
          q.delete(0);
          pops[k]++;
        end
      end
    end
    chk("ready", k, 32'(rd[k]), 32'(!ov[k] || rdy));
    pst[k] = ov[k] && !rdy;
    pout[k] = got[k];
    if (pst[k]) stalls[k]++;
    if (vin && rd[k])
      q.push_back('{lit_on ? lit_exp : model(op, a, b),
                    cyc, stalls[k]});
  endtask

  always @(negedge clk) begin
    mon(0, 1, q0);
    mon(1, 2, q1);
    mon(2, 4, q2);
    if (end_req) begin
      chk("drain", 0, q0.size(), 0);
      chk("drain", 1, q1.size(), 0);
      chk("drain", 2, q2.size(), 0);
      chk("seq_accept", 1, seq_acc, 8);
      chk("seq_out", 1, seq_delta, 8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input logic [2:0] o, input logic [7:0] x,
                     input logic [7:0] y, input logic [11:0] e);
    op = o;
    a = x;
    b = y;
    lit_on = 1'b1;
    lit_exp = e;
    vin = 1'b1;
    tick();
    vin = 1'b0;
    lit_on = 1'b0;
    repeat (6) tick();
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] edge_v [4];
    edge_v[0] = 8'h00;
    edge_v[1] = 8'h7F;
    edge_v[2] = 8'h80;
    edge_v[3] = 8'hFF;
    if (($urandom % 4) == 0) return edge_v[$urandom % 4];
    return 8'($urandom);
  endfunction

  initial begin
    int bi;
    int p0;
    logic acc;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    dir(3'd0, 8'hFF, 8'h01, 12'h500);
    dir(3'd2, 8'h70, 8'h20, 12'h27F);
    dir(3'd3, 8'h80, 8'h01, 12'hA80);
    dir(3'd7, 8'hFF, 8'h01, 12'h001);
    dir(3'd1, 8'h01, 8'h02, 12'h9FF);
    dir(3'd4, 8'hF0, 8'h0F, 12'h400);

    p0 = pops[1];
    bi = 0;
    op = 3'($urandom % 8);
    a = pick();
    b = pick();
    for (int c = 0; c < 40 && bi < 8; c++) begin
      vin = 1'b1;
      rdy = !(c >= 3 && c <= 6);
      @(negedge clk);
      acc = rd[1];
      tick();
      if (acc) begin
        bi++;
        op = 3'($urandom % 8);
        a = pick();
        b = pick();
      end
    end
    vin = 1'b0;
    rdy = 1'b1;
    repeat (8) tick();
    seq_acc = bi;
    seq_delta = pops[1] - p0;

    vin = 1'b1;
    op = 3'd0;
    a = 8'h11;
    b = 8'h22;
    tick();
    op = 3'd6;
    a = 8'h5A;
    tick();
    vin = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();

    for (int i = 0; i < 1500; i++) begin
      vin = ($urandom % 10) < 7;
      rdy = ($urandom % 4) != 0;
      op = 3'($urandom % 8);
      a = pick();
      b = pick();
      tick();
    end
    vin = 1'b0;
    rdy = 1'b1;
    repeat (8) tick();

    end_req = 1'b1;
    @(negedge clk);
    #1;
    end_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
